// File: rtl/spi_master.sv
// SPI byte master: full-duplex 8-bit transfer to one of three slaves over 9 active clocks.
// Define SPI_MASTER_MSB_FIRST_EN to shift MSB-first; the default build shifts LSB-first.
`timescale 1ns/1ps

module spi_master (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] slaveSelect,
    input  logic [7:0] masterDataToSend,
    output logic [7:0] masterDataReceived,
    output logic       SCLK,
    output logic [0:2] CS,
    output logic       MOSI,
    input  logic       MISO
);

    // Handshake: start is honoured only on an edge where flag=1 (idle); once the
    // transfer is accepted, start, slaveSelect and masterDataToSend are ignored
    // until flag returns to 1 on the completion edge.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      state;
    logic        flag;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [3:0]  bit_cnt;
    logic        tx_bit;
    logic [7:0]  rx_next;
    logic [0:2]  cs_sel;

    always_comb begin
        tx_bit  = 1'b0;
        rx_next = rx_sr;
`ifdef SPI_MASTER_MSB_FIRST_EN
        tx_bit  = tx_sr[3'd7 - bit_cnt[2:0]];
        rx_next = {rx_sr[6:0], MISO};
`else
        tx_bit  = tx_sr[bit_cnt[2:0]];
        rx_next = {MISO, rx_sr[7:1]};
`endif
    end

    // slaveSelect=3 runs the transfer with no chip select asserted.
    always_comb begin
        cs_sel = 3'b111;
        case (slaveSelect)
            2'd0:    cs_sel = 3'b011;
            2'd1:    cs_sel = 3'b101;
            2'd2:    cs_sel = 3'b110;
            default: cs_sel = 3'b111;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            flag               <= 1'b1;
            CS                 <= 3'b111;
            MOSI               <= 1'b0;
            masterDataReceived <= 8'h00;
            tx_sr              <= 8'h00;
            rx_sr              <= 8'h00;
            bit_cnt            <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_ACTIVE;
                        flag    <= 1'b0;
                        tx_sr   <= masterDataToSend;
                        rx_sr   <= 8'h00;
                        bit_cnt <= 4'd0;
                        CS      <= cs_sel;
                        MOSI    <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd7) begin
                        MOSI <= tx_bit;
                    end
                    if (bit_cnt >= 4'd1) begin
                        rx_sr <= rx_next;
                    end
                    // Count 8 samples the last MISO bit and closes the frame.
                    if (bit_cnt == 4'd8) begin
                        state              <= ST_IDLE;
                        flag               <= 1'b1;
                        masterDataReceived <= rx_next;
                        CS                 <= 3'b111;
                        MOSI               <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    flag  <= 1'b1;
                end
            endcase
        end
    end

    assign SCLK = clk & ~flag;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of transfers plus hand-written
// sequences for start held high and reset mid-transfer.
`timescale 1ns/1ps

module tb_spi_master;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] slaveSelect;
    logic [7:0] masterDataToSend;
    logic [7:0] masterDataReceived;
    logic       SCLK;
    logic [0:2] CS;
    logic       MOSI;
    logic       MISO;

    int errors = 0;
    int checks = 0;

    // Slave model state.
    logic [7:0] slv_tx;
    logic [7:0] mosi_sr;
    logic [0:2] exp_cs;
    logic       cs_ok;
    int         slv_n;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] tx;
        logic [7:0] sb;
        logic [0:2] cs;
    } vec_t;

    vec_t vecs[6];

    spi_master dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .slaveSelect        (slaveSelect),
        .masterDataToSend   (masterDataToSend),
        .masterDataReceived (masterDataReceived),
        .SCLK               (SCLK),
        .CS                 (CS),
        .MOSI               (MOSI),
        .MISO               (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: samples MOSI and updates MISO on falling edges while the master is active.
    always @(negedge clk) begin
        if (!dut.flag) begin
`ifdef SPI_MASTER_MSB_FIRST_EN
            mosi_sr = {mosi_sr[6:0], MOSI};
            if (slv_n >= 1 && slv_n <= 8) MISO = slv_tx[8 - slv_n];
`else
            mosi_sr = {MOSI, mosi_sr[7:1]};
            if (slv_n >= 1 && slv_n <= 8) MISO = slv_tx[slv_n - 1];
`endif
            if (CS !== exp_cs) cs_ok = 1'b0;
            slv_n = slv_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives start on a falling edge and returns 1ns after accepting edge k.
    task automatic launch(input logic [1:0] sel, input logic [7:0] tx,
                          input logic [7:0] sb, input logic [0:2] cs, input bit hold);
        @(negedge clk);
        slv_tx           = sb;
        slv_n            = 0;
        mosi_sr          = 8'h00;
        exp_cs           = cs;
        cs_ok            = 1'b1;
        start            = 1'b1;
        slaveSelect      = sel;
        masterDataToSend = tx;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        slaveSelect      = ~sel;
        masterDataToSend = ~tx;
    endtask

    // Runs edges k+1..k+9 and checks the completed transfer.
    task automatic complete(input logic [7:0] tx, input logic [7:0] sb);
        @(posedge clk);
        #1;
        check("sclk_active", {31'd0, SCLK}, 32'd1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("flag_low_k8", {31'd0, dut.flag}, 32'd0);
        @(posedge clk);
        #1;
        check("flag_high_k9", {31'd0, dut.flag}, 32'd1);
        check("rx_byte", {24'd0, masterDataReceived}, {24'd0, sb});
        check("slave_got_tx", {24'd0, mosi_sr}, {24'd0, tx});
        check("cs_during", {31'd0, cs_ok}, 32'd1);
        check("cs_after", {29'd0, CS}, 32'd7);
        check("mosi_after", {31'd0, MOSI}, 32'd0);
        check("sclk_idle", {31'd0, SCLK}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{sel: 2'd1, tx: 8'b01010011, sb: 8'b00001001, cs: 3'b101};
        vecs[1] = '{sel: 2'd0, tx: 8'b00111100, sb: 8'b10011000, cs: 3'b011};
        vecs[2] = '{sel: 2'd2, tx: 8'b01010101, sb: 8'b11111111, cs: 3'b110};
        vecs[3] = '{sel: 2'd1, tx: 8'b01011111, sb: 8'b10011000, cs: 3'b101};
        vecs[4] = '{sel: 2'd3, tx: 8'hA5,       sb: 8'h3C,       cs: 3'b111};
        vecs[5] = '{sel: 2'd2, tx: 8'hFF,       sb: 8'h81,       cs: 3'b110};

        reset            = 1'b0;
        start            = 1'b0;
        slaveSelect      = 2'd0;
        masterDataToSend = 8'h00;
        MISO             = 1'b0;
        slv_tx           = 8'h00;
        mosi_sr          = 8'h00;
        exp_cs           = 3'b111;
        cs_ok            = 1'b1;
        slv_n            = 0;

        // Clock and reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {29'd0, CS}, 32'd7);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_sclk", {31'd0, SCLK}, 32'd0);
        check("rst_rx", {24'd0, masterDataReceived}, 32'd0);
        check("rst_flag", {31'd0, dut.flag}, 32'd1);

        // Reset asserted at edge k+4 aborts the transfer without updating the result.
        launch(2'd1, 8'hC3, 8'h5A, 3'b101, 1'b0);
        repeat (4) @(posedge clk);
        reset = 1'b0;
        #1;
        check("abort_flag", {31'd0, dut.flag}, 32'd1);
        check("abort_cs", {29'd0, CS}, 32'd7);
        check("abort_mosi", {31'd0, MOSI}, 32'd0);
        check("abort_rx", {24'd0, masterDataReceived}, 32'd0);
        check("abort_sclk", {31'd0, SCLK}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        launch(2'd0, 8'h96, 8'h4E, 3'b011, 1'b0);
        complete(8'h96, 8'h4E);

        // Table: back-to-back transfers, one start every 10 cycles.
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].sel, vecs[i].tx, vecs[i].sb, vecs[i].cs, 1'b0);
            complete(vecs[i].tx, vecs[i].sb);
        end

        // Start held high through the transfer must not restart it.
        launch(2'd2, 8'h3A, 8'hC5, 3'b110, 1'b1);
        complete(8'h3A, 8'hC5);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_no_restart", {31'd0, dut.flag}, 32'd1);
        check("hold_rx_kept", {24'd0, masterDataReceived}, 32'hC5);

        // Result holds while idle.
        repeat (4) @(posedge clk);
        #1;
        check("rx_hold", {24'd0, masterDataReceived}, 32'hC5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
